// File: rtl/fetch_pc_unit_if.sv
// Decoder-side handshake of the fetch stage: head-of-queue {pc, instr} with valid/ready.
// The fetch unit drives it through the master modport; the decoder uses the slave modport.
interface fetch_pc_unit_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter plus small fetch queue feeding the decoder; redirect flushes, end of program halts.
// Optional macro FETCH_PERF_EN adds fetch_cnt_o / stall_cnt_o performance counters.
//
// state  | meaning
// S_RUN  | fetching one instruction per cycle while the queue has room
// S_HALT | past end of program (or redirected out of range); queue only drains
module fetch_pc_unit #(
    parameter int PC_W      = 32,
    parameter int INSTR_W   = 32,
    parameter int RESET_PC  = 0,
    parameter int MEM_WORDS = 6,
    parameter int QDEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    fetch_pc_unit_if.master    dec,
    output logic               halted_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        stall_cnt_o
`endif
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(MEM_WORDS - 1);
    localparam logic [PC_W-1:0]  MEM_LIM  = PC_W'(MEM_WORDS);
    localparam logic [PC_W-1:0]  RST_PC   = PC_W'(RESET_PC);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [PC_W-1:0]    r_q_pc    [QDEPTH];
    logic [INSTR_W-1:0] r_q_instr [QDEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               w_deq;
    logic               w_full;
    logic               w_fetch;

    assign pc_o          = r_pc;
    assign halted_o      = (r_state == S_HALT);
    assign dec.out_valid = (r_count != '0);
    assign dec.out_pc    = r_q_pc[r_head];
    assign dec.out_instr = r_q_instr[r_head];

    always_comb begin
        w_deq       = dec.out_valid & dec.out_ready;
        w_full      = (r_count == FULL_CNT);
        w_fetch     = (r_state == S_RUN) & ~redirect_i & (~w_full | w_deq);
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (redirect_i) begin
            w_pc_nxt    = redirect_pc_i;
            w_state_nxt = (redirect_pc_i >= MEM_LIM) ? S_HALT : S_RUN;
        end else if (w_fetch) begin
            // The last word is fetched once; pc stays on it while halted.
            if (r_pc == LAST_PC) begin
                w_state_nxt = S_HALT;
            end else begin
                w_pc_nxt = r_pc + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_pc    <= RST_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (redirect_i) begin
                // Flush wins over a same-cycle dequeue; the dequeue is still taken by the decoder.
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_fetch) begin
                    r_q_pc[r_tail]    <= r_pc;
                    r_q_instr[r_tail] <= instr_i;
                    r_tail            <= r_tail + PTR_W'(1);
                end
                if (w_deq) begin
                    r_head <= r_head + PTR_W'(1);
                end
                if (w_fetch && !w_deq) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_deq && !w_fetch) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    assign fetch_cnt_o = r_fetch_cnt;
    assign stall_cnt_o = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_fetch) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (dec.out_valid && !dec.out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a 6-word instruction memory holding mem[k] = k + 0x100.
module tb_fetch_pc_unit;
    logic        clk;
    logic        rst_n;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halted_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif
    int n_tests;
    int n_fail;

    fetch_pc_unit_if #(.PC_W(32), .INSTR_W(32)) dif ();

    fetch_pc_unit #(
        .PC_W(32), .INSTR_W(32), .RESET_PC(0), .MEM_WORDS(6), .QDEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .dec           (dif.master),
        .halted_o      (halted_o)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    assign instr_i = (pc_o < 32'd6) ? (32'h100 + pc_o) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; dif.out_ready = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (pc_o !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %0d exp 0", pc_o); end
        n_tests++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", dif.out_valid); end
        n_tests++; if (dif.out_pc !== 32'd0 || dif.out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_out got pc=%0d instr=%h exp 0/0", dif.out_pc, dif.out_instr); end
        n_tests++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b exp 0", halted_o); end
    endtask

    task automatic test_stream();
        do_reset();
        rst_n = 1'b1; dif.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'(k) || dif.out_instr !== 32'(k + 'h100)) begin
                n_fail++;
                $display("FAIL stream[%0d] got v=%b pc=%0d instr=%h exp v=1 pc=%0d instr=%h",
                         k, dif.out_valid, dif.out_pc, dif.out_instr, k, k + 'h100);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rst_n = 1'b1; dif.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_tests++; if (pc_o !== 32'd2) begin n_fail++; $display("FAIL bp_pc got %0d exp 2", pc_o); end
        n_tests++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'd0) begin n_fail++; $display("FAIL bp_head got v=%b pc=%0d exp v=1 pc=0", dif.out_valid, dif.out_pc); end
        dif.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            n_tests++;
            if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'(k) || dif.out_instr !== 32'(k + 'h100)) begin
                n_fail++;
                $display("FAIL bp_drain[%0d] got v=%b pc=%0d exp v=1 pc=%0d", k, dif.out_valid, dif.out_pc, k);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        rst_n = 1'b1; dif.out_ready = 1'b0;
        step(); step();
        dif.out_ready = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'd4;
        step();
        redirect_i = 1'b0;
        n_tests++; if (dif.out_valid !== 1'b0 || pc_o !== 32'd4) begin n_fail++; $display("FAIL redir_flush got v=%b pc_o=%0d exp v=0 pc_o=4", dif.out_valid, pc_o); end
        step();
        n_tests++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'd4 || dif.out_instr !== 32'h104) begin n_fail++; $display("FAIL redir_target got v=%b pc=%0d instr=%h exp v=1 pc=4 instr=104", dif.out_valid, dif.out_pc, dif.out_instr); end
    endtask

    task automatic test_halt();
        do_reset();
        rst_n = 1'b1; dif.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        n_tests++; if (halted_o !== 1'b1 || pc_o !== 32'd5 || dif.out_pc !== 32'd5) begin n_fail++; $display("FAIL halt_end got h=%b pc_o=%0d out_pc=%0d exp h=1 pc_o=5 out_pc=5", halted_o, pc_o, dif.out_pc); end
        step(); step();
        n_tests++; if (dif.out_valid !== 1'b0 || pc_o !== 32'd5 || halted_o !== 1'b1) begin n_fail++; $display("FAIL halt_idle got v=%b pc_o=%0d h=%b exp v=0 pc_o=5 h=1", dif.out_valid, pc_o, halted_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'd0;
        step();
        redirect_i = 1'b0;
        n_tests++; if (halted_o !== 1'b0 || pc_o !== 32'd0) begin n_fail++; $display("FAIL halt_leave got h=%b pc_o=%0d exp h=0 pc_o=0", halted_o, pc_o); end
        step();
        n_tests++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'd0) begin n_fail++; $display("FAIL halt_restart got v=%b pc=%0d exp v=1 pc=0", dif.out_valid, dif.out_pc); end
        redirect_i = 1'b1; redirect_pc_i = 32'd9;
        step();
        redirect_i = 1'b0;
        step();
        n_tests++; if (halted_o !== 1'b1 || dif.out_valid !== 1'b0 || pc_o !== 32'd9) begin n_fail++; $display("FAIL halt_oob got h=%b v=%b pc_o=%0d exp h=1 v=0 pc_o=9", halted_o, dif.out_valid, pc_o); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        rst_n = 1'b1; dif.out_ready = 1'b0;
        step(); step();
        rst_n = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'd3; dif.out_ready = 1'b1;
        step();
        redirect_i = 1'b0;
        n_tests++; if (pc_o !== 32'd0 || dif.out_valid !== 1'b0 || halted_o !== 1'b0) begin n_fail++; $display("FAIL rst_prio got pc_o=%0d v=%b h=%b exp 0/0/0", pc_o, dif.out_valid, halted_o); end
        n_tests++; if (dif.out_pc !== 32'd0 || dif.out_instr !== 32'd0) begin n_fail++; $display("FAIL rst_prio_out got pc=%0d instr=%h exp 0/0", dif.out_pc, dif.out_instr); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        rst_n = 1'b1; dif.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        n_tests++; if (fetch_cnt_o !== 32'd5 || stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL perf_run got f=%0d s=%0d exp 5/0", fetch_cnt_o, stall_cnt_o); end
        dif.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        n_tests++; if (fetch_cnt_o !== 32'd6 || stall_cnt_o !== 32'd3) begin n_fail++; $display("FAIL perf_stall got f=%0d s=%0d exp 6/3", fetch_cnt_o, stall_cnt_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'd0;
        step();
        redirect_i = 1'b0;
        n_tests++; if (fetch_cnt_o !== 32'd6 || stall_cnt_o !== 32'd4) begin n_fail++; $display("FAIL perf_redir got f=%0d s=%0d exp 6/4", fetch_cnt_o, stall_cnt_o); end
    endtask
`endif

    initial begin
        n_tests = 0; n_fail = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_priority();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
